// File: rtl/mac_operand_seq.sv
// rtl/mac_operand_seq.sv - sequences packed attribute/coefficient vectors into MAC operand terms
module mac_operand_seq #(
    parameter int N_TERMS    = 3,
    parameter int ELEM_W     = 8,
    parameter int MAC_LAT    = 2,
    parameter int SIGNED_EXT = 0
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_TERMS*ELEM_W-1:0] attr_vec,
    input  logic [N_TERMS*ELEM_W-1:0] coeff_vec,
    input  logic                      hold,
    output logic [15:0]               A,
    output logic [15:0]               B,
    output logic                      CE,
    output logic                      CARRYIN,
    output logic                      ACC_LOAD,
    output logic                      result_valid,
    output logic                      busy
);

    localparam int KW = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(N_TERMS - 1);
    localparam logic [2:0] LAST_D = 3'(MAC_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_d;

    logic [KW-1:0]               k_q, k_d, k_nx;
    logic [2:0]                  dcnt_q, dcnt_d;
    logic [N_TERMS*ELEM_W-1:0]   attr_q, attr_d;
    logic [N_TERMS*ELEM_W-1:0]   coeff_q, coeff_d;
    logic [15:0]                 a_q, a_d;
    logic [15:0]                 b_q, b_d;
    logic                        ce_q, ce_d;
    logic                        ld_q, ld_d;

    // Widen one element to the 16-bit MAC port, zero- or sign-filling the upper bits.
    function automatic logic [15:0] ext(input logic [ELEM_W-1:0] e);
        logic [15:0] r;
        r = '0;
        r[ELEM_W-1:0] = e;
        for (int i = ELEM_W; i < 16; i++) begin
            r[i] = (SIGNED_EXT != 0) ? e[ELEM_W-1] : 1'b0;
        end
        return r;
    endfunction

    // Select element idx from a packed vector.
    function automatic logic [ELEM_W-1:0] pick(input logic [N_TERMS*ELEM_W-1:0] v,
                                              input logic [KW-1:0] idx);
        return v[int'(idx)*ELEM_W +: ELEM_W];
    endfunction

    assign k_nx = k_q + KW'(1);

    // Next-state and next-operand logic; the operands are registered so each
    // term appears the cycle after the decision that selects it.
    always_comb begin
        state_d = state;
        k_d     = k_q;
        dcnt_d  = dcnt_q;
        attr_d  = attr_q;
        coeff_d = coeff_q;
        a_d     = a_q;
        b_d     = b_q;
        ce_d    = ce_q;
        ld_d    = ld_q;
        case (state)
            IDLE: begin
                a_d    = '0;
                b_d    = '0;
                ce_d   = 1'b0;
                ld_d   = 1'b0;
                dcnt_d = '0;
                k_d    = '0;
                if (in_valid) begin
                    attr_d  = attr_vec;
                    coeff_d = coeff_vec;
                    a_d     = ext(pick(attr_vec, '0));
                    b_d     = ext(pick(coeff_vec, '0));
                    ce_d    = 1'b1;
                    ld_d    = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A held term stays on A/B untouched; only the gated CE tells
                // the MAC not to consume it.
                if (!hold) begin
                    if (k_q == LAST_K) begin
                        a_d    = '0;
                        b_d    = '0;
                        ld_d   = 1'b0;
                        dcnt_d = '0;
                        if (MAC_LAT == 0) begin
                            ce_d    = 1'b0;
                            state_d = DONE;
                        end else begin
                            ce_d    = 1'b1;
                            state_d = DRAIN;
                        end
                    end else begin
                        k_d  = k_nx;
                        a_d  = ext(pick(attr_q, k_nx));
                        b_d  = ext(pick(coeff_q, k_nx));
                        ce_d = 1'b1;
                        ld_d = 1'b0;
                    end
                end
            end
            DRAIN: begin
                // Zero operands keep the MAC clocked until its pipeline empties.
                if (!hold) begin
                    if (dcnt_q == LAST_D) begin
                        ce_d    = 1'b0;
                        state_d = DONE;
                    end else begin
                        dcnt_d = dcnt_q + 3'd1;
                    end
                end
            end
            DONE: begin
                a_d  = '0;
                b_d  = '0;
                ce_d = 1'b0;
                ld_d = 1'b0;
                if (!hold) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, index, drain counter, latched vectors and operand registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            k_q     <= '0;
            dcnt_q  <= '0;
            attr_q  <= '0;
            coeff_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ce_q    <= 1'b0;
            ld_q    <= 1'b0;
        end else begin
            state   <= state_d;
            k_q     <= k_d;
            dcnt_q  <= dcnt_d;
            attr_q  <= attr_d;
            coeff_q <= coeff_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ce_q    <= ce_d;
            ld_q    <= ld_d;
        end
    end

    assign A            = a_q;
    assign B            = b_q;
    assign ACC_LOAD     = ld_q;
    // A stall must stop the MAC in the same cycle, so CE is gated by hold directly.
    assign CE           = ce_q & ~hold;
    assign CARRYIN      = 1'b0;
    assign result_valid = (state == DONE);
    assign busy         = (state != IDLE);
    assign in_ready     = (state == IDLE) && !RST;

endmodule
